hazard_unit_mc: RTL
===================

Name: hazard_unit_mc

Overview:
- Next-generation hazard unit for the 5-stage pipelined RV32 core. It replaces the single-cycle-execute hazard logic.
- Adds parametrised register-address width and a multi-cycle execute (divider) occupancy FSM.
- Covers EX forwarding, load-use stall and taken-branch flush. Adds stall of F/D/E with bubble injection into M while a multi-cycle op holds E.
- Sits beside controller and datapath in the core top. It drives the datapath's Stall/Flush/Forward inputs.

Parameters:
- REG_AW, 5, register address width (Rs/Rd fields)
- DIV_LAT, 8, cycles E is held by a multi-cycle op; legal range 1..255
- CNT_W, 8, counter width; must hold DIV_LAT-1

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- Rs1D, Rs2D  in  REG_AW  source regs in Decode
- Rs1E, Rs2E  in  REG_AW  source regs in Execute
- RdE, RdM, RdW  in  REG_AW  dest regs in E/M/W
- RegWriteM, RegWriteW  in  1  writeback enables in M/W
- ResultSrcE0  in  1  instruction in E is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- DivStartE  in  1  instruction in E is multi-cycle; held high while it sits in E
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = W result, 10 = M ALU result
- StallF, StallD, StallE  out  1  hold PC, IF/ID, ID/EX
- FlushD, FlushE, FlushM  out  1  clear IF/ID, ID/EX, EX/MEM
- DivBusy  out  1  FSM in BUSY
- DivDoneE  out  1  one-cycle pulse: multi-cycle result valid in E this cycle

Behaviour:
- Forwarding (combinational), evaluated per operand:
  - 10 if RegWriteM, RdM!=0 and RdM==Rs1E (Rs2E for B).
  - Else 01 if RegWriteW, RdW!=0 and RdW==Rs1E/Rs2E.
  - Else 00.
  - M has priority over W.
- lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- FSM states and transitions:
  - States: IDLE, BUSY. Counter cnt is CNT_W bits.
  - IDLE & DivStartE -> BUSY, cnt <= DIV_LAT-1.
  - BUSY & cnt!=0 -> cnt <= cnt-1.
  - BUSY & cnt==0 -> IDLE; DivDoneE=1 this cycle.
  - DivStartE is ignored in BUSY, including the done cycle.
  - A back-to-back multi-cycle op restarts from IDLE on the following cycle.
- divStall = (IDLE & DivStartE) | (BUSY & cnt!=0). It is asserted for exactly DIV_LAT consecutive cycles. E is occupied for DIV_LAT+1 cycles.
- Output priority:
  1. divStall: StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0. lwStall and PCSrcE are ignored; a multi-cycle op is never a branch.
  2. Otherwise:
     - StallF=StallD=lwStall; StallE=0; FlushM=0.
     - FlushD=PCSrcE; FlushE=lwStall|PCSrcE.
     - lwStall and PCSrcE together: both apply.
- DivBusy = (state==BUSY), registered state.
- Reset (reset==0 at rising edge): state<=IDLE, cnt<=0. Reset mid-BUSY aborts the op with no DivDoneE.
- While reset==0, outputs are forced: Stall*=0, Flush*=1, Forward*=00, DivBusy=0 (after the edge), DivDoneE=0.
- Register index 0 never matches, for both forwarding and stall.
- All outputs except DivBusy are combinational from inputs and state.

Test Plan:
1. add x5 in M (RegWriteM=1, RdM=5) and x5 in W; Rs1E=5 -> ForwardAE=10. Drop RegWriteM -> 01. RdM=RdW=0, Rs1E=0 -> 00.
2. Load in E (ResultSrcE0=1, RdE=7), Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. RdE=0 -> no stall.
3. PCSrcE=1, no other hazard -> FlushD=FlushE=1, Stall*=0.
4. DIV_LAT=8, DivStartE=1 held from cycle t:
   - Stall F/D/E and FlushM=1 during cycles t..t+7.
   - DivBusy=1 during t+1..t+8.
   - DivDoneE=1 only at t+8; stalls low at t+8.
   - Repeat with DIV_LAT=1: stall only at t, done at t+1.
5. Back-to-back multi-cycle ops: second DivStartE at t+9 -> new 8-cycle stall. lwStall and PCSrcE asserted during BUSY -> no FlushD/FlushE.
6. reset=0 at t+3 of a BUSY sequence -> next cycle IDLE, DivBusy=0, no DivDoneE. After release, DivStartE restarts the full DIV_LAT count.

Source files
------------

// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit signal bundle between the pipeline datapath and the hazard unit.
// master = datapath side (drives register fields/enables), slave = hazard unit.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] RdM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              ResultSrcE0;
  logic              PCSrcE;
  logic              DivStartE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              DivBusy;
  logic              DivDoneE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, DivStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, DivBusy, DivDoneE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, DivStartE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, DivBusy, DivDoneE
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32 core: EX forwarding, load-use stall, branch flush,
// and an occupancy FSM that freezes F/D/E while a multi-cycle (divider) op holds Execute.
module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  hazard_unit_mc_if.slave  hz
);
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_div_stall;
  logic             w_div_done;
  logic             w_lw_stall;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // M stage wins over W; register 0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              reg_write_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              reg_write_w,
    input logic [REG_AW-1:0] rd_w
  );
    if (reg_write_m && (rd_m != ZERO_REG) && (rd_m == rs))
      return 2'b10;
    else if (reg_write_w && (rd_w != ZERO_REG) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_fwd_a = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign w_fwd_b = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

  assign w_lw_stall = hz.ResultSrcE0 && (hz.RdE != ZERO_REG) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // DivStartE is not looked at in BUSY, so a held start only re-arms once back in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_div_stall  = 1'b0;
    w_div_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (hz.DivStartE) begin
          w_state_next = S_BUSY;
          w_cnt_next   = CNT_LOAD;
          w_div_stall  = 1'b1;
        end
      end
      S_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_next  = r_cnt - CNT_ONE;
          w_div_stall = 1'b1;
        end else begin
          w_state_next = S_IDLE;
          w_div_done   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.DivDoneE  = 1'b0;
    if (!reset) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushM = 1'b1;
    end else begin
      hz.ForwardAE = w_fwd_a;
      hz.ForwardBE = w_fwd_b;
      hz.DivDoneE  = w_div_done;
      if (w_div_stall) begin
        // Freeze the front end and push a bubble into M; a divide is never a branch.
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.FlushM = 1'b1;
      end else begin
        hz.StallF = w_lw_stall;
        hz.StallD = w_lw_stall;
        hz.FlushD = hz.PCSrcE;
        hz.FlushE = w_lw_stall || hz.PCSrcE;
      end
    end
  end

  assign hz.DivBusy = (r_state == S_BUSY);
endmodule
